// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low {a..g} pattern type, hex code
// table and the scan-decoder FSM state encoding.
package seg7_pkg;

  typedef logic [6:0] seg7_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } fsm_state_t;

  localparam seg7_code_t SEG_BLANK = 7'b1111111;

  // Index is the hex digit; entries are {CA,CB,CC,CD,CE,CF,CG}, active-low.
  localparam seg7_code_t HEX_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern into a hex nibble.
// Blank and unrecognised patterns both yield nibble 0.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] nibble_o,
  output logic       is_blank_o,
  output logic       is_err_o
);

  logic hit;

  always_comb begin
    nibble_o   = '0;
    hit        = 1'b0;
    is_blank_o = (pattern_i == SEG_BLANK);
    for (int unsigned k = 0; k < 16; k++) begin
      if (pattern_i == HEX_TABLE[k]) begin
        nibble_o = 4'(k);
        hit      = 1'b1;
      end
    end
    is_err_o = !hit && !is_blank_o;
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Watches a multiplexed seven-segment display, captures each digit once its
// strobe and segments have been stable long enough, and publishes whole frames.
module seven_seg_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_DIGITS    = 8
) (
  input  logic                      clk_100,
  input  logic                      reset,
  input  logic                      CA,
  input  logic                      CB,
  input  logic                      CC,
  input  logic                      CD,
  input  logic                      CE,
  input  logic                      CF,
  input  logic                      CG,
  input  logic                      DP,
  input  logic [NUM_DIGITS-1:0]     AN,
  output logic [4*NUM_DIGITS-1:0]   value,
  output logic [NUM_DIGITS-1:0]     dp_mask,
  output logic [NUM_DIGITS-1:0]     blank_mask,
  output logic [NUM_DIGITS-1:0]     err_mask,
  output logic                      frame_valid
);

  localparam int unsigned SW = 8 + NUM_DIGITS;

  logic [SW-1:0]           s_q, s_prev_q;
  fsm_state_t              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] wval_q;
  logic [NUM_DIGITS-1:0]   wdp_q, wblank_q, werr_q;

  logic [6:0]            s_seg;
  logic                  s_dp_n;
  logic [NUM_DIGITS-1:0] s_an;
  logic                  one_hot, changed, capture, publish;
  logic [3:0]            dec_nibble;
  logic                  dec_blank, dec_err;

  assign s_seg   = s_q[SW-1 -: 7];
  assign s_dp_n  = s_q[NUM_DIGITS];
  assign s_an    = s_q[NUM_DIGITS-1:0];
  assign one_hot = $onehot(~s_an);
  assign changed = (s_q != s_prev_q);
  assign publish = &seen_q;

  seg7_pattern_decode u_decode (
    .pattern_i  (s_seg),
    .nibble_o   (dec_nibble),
    .is_blank_o (dec_blank),
    .is_err_o   (dec_err)
  );

  // The counter holds the number of identical samples seen so far, so the
  // first sample of a new value already counts as 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (one_hot) begin
          state_d = SETTLE;
          cnt_d   = 8'd1;
        end
      end
      SETTLE: begin
        if (!one_hot) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (changed) begin
          cnt_d = 8'd1;
        end else begin
          cnt_d = 8'(cnt_q + 8'd1);
        end
      end
      HOLD: begin
        if (changed) begin
          state_d = one_hot ? SETTLE : IDLE;
          cnt_d   = one_hot ? 8'd1 : 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (state_d == SETTLE && cnt_d == 8'(SETTLE_CYCLES)) begin
      capture = 1'b1;
      state_d = HOLD;
    end
    seen_d = (publish ? '0 : seen_q) | (capture ? ~s_an : '0);
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      s_q         <= '0;
      s_prev_q    <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      seen_q      <= '0;
      wval_q      <= '0;
      wdp_q       <= '0;
      wblank_q    <= '0;
      werr_q      <= '0;
      value       <= '0;
      dp_mask     <= '0;
      blank_mask  <= '0;
      err_mask    <= '0;
      frame_valid <= 1'b0;
    end else begin
      s_q      <= {CA, CB, CC, CD, CE, CF, CG, DP, AN};
      s_prev_q <= s_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seen_q   <= seen_d;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (capture && !s_an[i]) begin
          wval_q[4*i +: 4] <= dec_nibble;
          wdp_q[i]         <= ~s_dp_n;
          wblank_q[i]      <= dec_blank;
          werr_q[i]        <= dec_err;
        end
      end
      frame_valid <= publish;
      if (publish) begin
        value      <= wval_q;
        dp_mask    <= wdp_q;
        blank_mask <= wblank_q;
        err_mask   <= werr_q;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for the seven-segment scan decoder: expected frames are
// queued by the stimulus and checked by an independent frame monitor.
module tb_seven_seg_scan_decoder;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  err;
  } frame_t;

  localparam logic [6:0] HX [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] BAD   = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ca = 1'b1, cb = 1'b1, cc = 1'b1, cd = 1'b1, ce = 1'b1, cf = 1'b1, cg = 1'b1;
  logic        dp = 1'b1;
  logic [7:0]  an = 8'hFF;
  logic [31:0] value;
  logic [7:0]  dp_mask, blank_mask, err_mask;
  logic        frame_valid;

  frame_t sb[$];
  int     tests = 0;
  int     fails = 0;
  int     nframes = 0;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(4), .NUM_DIGITS(8)) dut (
    .clk_100     (clk),
    .reset       (rst),
    .CA          (ca),
    .CB          (cb),
    .CC          (cc),
    .CD          (cd),
    .CE          (ce),
    .CF          (cf),
    .CG          (cg),
    .DP          (dp),
    .AN          (an),
    .value       (value),
    .dp_mask     (dp_mask),
    .blank_mask  (blank_mask),
    .err_mask    (err_mask),
    .frame_valid (frame_valid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one digit strobe with the given pattern for n clock edges.
  task automatic show(input int d, input logic [6:0] code, input logic dp_n, input int n);
    {ca, cb, cc, cd, ce, cf, cg} = code;
    dp = dp_n;
    an = ~(8'b1 << d);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    an = 8'hFF;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input logic [31:0] v, input logic [7:0] d,
                              input logic [7:0] b, input logic [7:0] e);
    frame_t f;
    f.value = v; f.dp = d; f.blank = b; f.err = e;
    sb.push_back(f);
  endtask

  // Monitor: every frame_valid must match the oldest queued frame.
  always @(negedge clk) begin
    if (frame_valid) begin
      nframes++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame: value %h arrived, no frame expected", value);
      end else begin
        frame_t e;
        e = sb.pop_front();
        chk("frame_value", value, e.value);
        chk("frame_dp",    {24'h0, dp_mask},    {24'h0, e.dp});
        chk("frame_blank", {24'h0, blank_mask}, {24'h0, e.blank});
        chk("frame_err",   {24'h0, err_mask},   {24'h0, e.err});
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_value"}, value, 32'h0);
    chk({tag, "_dp"},    {24'h0, dp_mask},    32'h0);
    chk({tag, "_blank"}, {24'h0, blank_mask}, 32'h0);
    chk({tag, "_err"},   {24'h0, err_mask},   32'h0);
    chk({tag, "_fv"},    {31'h0, frame_valid}, 32'h0);
  endtask

  initial begin
    int clean_codes [8];
    clean_codes = '{8, 15, 11, 10, 1, 0, 0, 1};

    repeat (3) @(negedge clk);
    chk_zero_outputs("reset_init");
    rst = 1'b0;
    @(posedge clk); #1;
    idle(3);

    // Clean frame: digits 0..7 = 8,F,b,A,1,0,0,1
    for (int i = 0; i < 7; i++) show(i, HX[clean_codes[i]], 1'b1, 10);
    expect_frame(32'h1001ABF8, 8'h00, 8'h00, 8'h00);
    show(7, HX[clean_codes[7]], 1'b1, 10);
    idle(3);

    // Reset after 5 digits of a partial frame discards it.
    for (int i = 0; i < 5; i++) show(i, HX[8], 1'b0, 10);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_zero_outputs("reset_mid");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    show(5, HX[7], 1'b1, 10);
    show(6, HX[9], 1'b1, 10);
    show(7, HX[5], 1'b1, 10);
    show(0, HX[12], 1'b1, 10);
    show(1, HX[13], 1'b1, 10);
    show(2, HX[14], 1'b1, 10);
    show(3, HX[2], 1'b1, 10);
    expect_frame(32'h59732EDC, 8'h00, 8'h00, 8'h00);
    show(4, HX[3], 1'b1, 10);
    idle(3);

    // Glitch: AN[3] low for only 3 samples must not mark digit 3 seen.
    show(3, HX[0], 1'b1, 3);
    idle(3);
    for (int i = 0; i < 8; i++) if (i != 3) show(i, HX[i + 1], 1'b1, 10);
    expect_frame(32'h87654321, 8'h00, 8'h00, 8'h00);
    show(3, HX[4], 1'b1, 10);
    idle(3);

    // Segment change during settle: digit 2 goes 1 -> A and captures A.
    show(0, HX[15], 1'b1, 10);
    show(1, HX[14], 1'b1, 10);
    show(3, HX[13], 1'b1, 10);
    show(4, HX[12], 1'b1, 10);
    show(5, HX[11], 1'b1, 10);
    show(6, HX[10], 1'b1, 10);
    show(7, HX[9], 1'b1, 10);
    expect_frame(32'h9ABCDAEF, 8'h00, 8'h00, 8'h00);
    show(2, HX[1], 1'b1, 2);
    show(2, HX[10], 1'b1, 10);
    idle(3);

    // DP on digit 5, blank digit 6, illegal pattern on digit 7.
    show(0, HX[2], 1'b1, 10);
    show(1, HX[3], 1'b1, 10);
    show(2, HX[4], 1'b1, 10);
    show(3, HX[5], 1'b1, 10);
    show(4, HX[6], 1'b1, 10);
    show(5, HX[9], 1'b0, 10);
    show(6, BLANK, 1'b1, 10);
    expect_frame(32'h00965432, 8'h20, 8'h40, 8'h80);
    show(7, BAD, 1'b1, 10);
    idle(3);

    // Two anodes low at once must never capture digit 2 or 3.
    {ca, cb, cc, cd, ce, cf, cg} = HX[8];
    dp = 1'b1;
    an = 8'b1111_0011;
    repeat (20) @(posedge clk);
    #1;
    idle(3);
    for (int i = 0; i < 8; i++) if (i != 2 && i != 3) show(i, HX[i], 1'b1, 10);
    show(2, HX[2], 1'b1, 10);
    expect_frame(32'h76543210, 8'h00, 8'h00, 8'h00);
    show(3, HX[3], 1'b1, 10);
    idle(20);

    chk("scoreboard_drained", sb.size(), 32'd0);
    chk("frame_count", nframes, 32'd6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, %0d frames seen", nframes);
    $fatal(1);
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
# seven_seg_scan_decoder

Receive-side counterpart to the board's multiplexed seven-segment driver. It watches the active-low anode strobes (AN) and segment lines (CA–CG, DP) and waits for each digit to settle. It then decodes every strobed segment pattern back into a hex nibble and assembles a full 8-digit frame into a 32-bit word. It sits beside `top` in simulation and on the board's debug path, giving self-checking benches and the LED/debug logic a numeric view of what the display is showing.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive stable samples (AN and segments unchanged) required before a digit is captured; legal range 1–255.
- `NUM_DIGITS`, default 8: digits per frame, equal to the AN width.
- `clk_100` input 1: system clock, 100 MHz. The block uses one clock.
- `reset` input 1: reset is asynchronous and active-high.
- `CA`..`CG` input 1 each: segment a..g, active-low.
- `DP` input 1: decimal point, active-low.
- `AN` input NUM_DIGITS: digit anodes, active-low; bit i selects digit i, and digit 0 is the least significant nibble.
- `value` output 4*NUM_DIGITS: last complete decoded frame, with digit i in bits [4i+3:4i].
- `dp_mask` output NUM_DIGITS: DP lit per digit in the last frame.
- `blank_mask` output NUM_DIGITS: digit was blank (all segments off) in the last frame; its nibble reads 0.
- `err_mask` output NUM_DIGITS: digit carried a non-hex, non-blank pattern in the last frame; its nibble reads 0.
- `frame_valid` output 1: one-cycle pulse when value, dp_mask, blank_mask and err_mask update.

## Operation
- **Input stage:** {CA..CG, DP, AN} are registered once (stage S). All decisions use S and the previous sample S_d.
- **Active-low encoding:** the 7-bit pattern is {CA,CB,CC,CD,CE,CF,CG}. Reference codes:
  - 0 = 0000001, 1 = 1001111, 8 = 0000000
  - A = 0001000, b = 1100000, F = 0111000
  - blank = 1111111
  - All 16 hex codes come from the package table.
- **FSM states:**
  - IDLE: AN is not exactly one bit low (all high or multi-low). The counter is held at 0. Go to SETTLE when AN becomes one-hot-low.
  - SETTLE: the counter increments each cycle while S == S_d. On any change in AN, segments or DP, the counter resets to 1 and the block stays in SETTLE, or goes to IDLE if AN is no longer one-hot. When the counter reaches SETTLE_CYCLES, it captures and goes to HOLD.
  - HOLD: the digit is already captured and no further capture happens. Any change in S goes to SETTLE (counter = 1) or to IDLE.
- **Capture:** writes the working nibble, dp, blank and err bits for index i, where AN[i] is low, and sets seen[i]. Recapturing a digit before the frame completes overwrites it.
- **Frame completion:** in the cycle after seen becomes all-ones, the working registers copy to the outputs, frame_valid pulses, and seen clears. Working registers are not cleared; their stale bits are overwritten on the next captures.
- **Reset:** clears all outputs, seen, the counter and stage S. The FSM returns to IDLE. A partial frame is discarded.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- Latency from an AN/segment edge at the pins to capture is 1 (input register) + SETTLE_CYCLES cycles, counting from when S first shows the new value.
- frame_valid rises 1 cycle after the final digit's capture edge and lasts exactly 1 cycle; outputs hold until the next frame.
- Outputs never change except on frame_valid or reset.
- Glitches shorter than SETTLE_CYCLES samples never capture.
- If a capture and frame completion would coincide, the capture that sets the last seen bit occurs first; publication is always the following cycle.

## Structure
- Package `seg7_pkg`:
  - `SEG_BLANK` constant
  - `seg7_code_t` (logic [6:0]) typedef
  - a 16-entry hex-to-pattern table
  - a `fsm_state_t` enum {IDLE, SETTLE, HOLD}
- Sub-module `seg7_pattern_decode` (combinational): pattern in; nibble, is_blank and is_err out. It is shared with any future encoder checks.
- The top level holds the input register, FSM, counter, seen mask, working registers and output registers.

## Test plan
- Reset mid-frame: assert reset after 5 digits, then complete a frame → no frame_valid until all 8 are re-seen after release; outputs stay 0 during reset.
- Clean frame: scan digits 0..7 with codes 8,F,b,A,1,0,0,1, each held 10 cycles → frame_valid once, value = 0x100_1AbF8 ordered as digit7..0 = 1,0,0,1,A,b,F,8, i.e. 0x1001AbF8; masks 0.
- Glitch rejection: with SETTLE_CYCLES=4, pulse AN[3] low for 3 cycles → no capture, and seen[3] stays 0.
- Segment change during settle: AN[2] held, pattern switches from 1 to A after 2 cycles → digit 2 captures A.
- DP/blank/error: digit 5 with DP=0, digit 6 blank, digit 7 with pattern 1111110 → dp_mask = 0x20, blank_mask = 0x40, err_mask = 0x80, and nibbles 6 and 7 read 0.
- Illegal AN: AN = 8'b1111_0011 held 20 cycles → FSM stays IDLE and no capture.
